// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension arbiter slice.
//  MODE_W      : width of a per-requester mode field
//  mode_e      : extension modes (sign, zero, sign<<2 branch offset, reserved)
//  slot_e      : response slot occupancy
package imm_ext_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_SIGN = 2'b00,
    MODE_ZERO = 2'b01,
    MODE_BR   = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

endpackage

// File: rtl/imm_ext_arbiter_if.sv
// Request/response bundle between requesters, the consumer and imm_ext_arbiter.
//  req_valid/req_ready : per-requester handshake
//  req_imm/req_mode    : packed immediates and modes, requester i at slice i
//  rsp_valid/rsp_ready : response slot handshake
//  rsp_data/rsp_id     : extended result and the requester that produced it
//  master modport: requester/consumer side; slave modport: arbiter side.
interface imm_ext_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IN_W    = 16,
  parameter int unsigned OUT_W   = 32
);
  import imm_ext_pkg::*;

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*IN_W-1:0]   req_imm;
  logic [NUM_REQ*MODE_W-1:0] req_mode;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [OUT_W-1:0]          rsp_data;
  logic [ID_W-1:0]           rsp_id;

  modport master (
    output req_valid, req_imm, req_mode, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_imm, req_mode, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/imm_ext_core.sv
// Combinational IN_W -> OUT_W immediate extension.
//  imm  : input immediate
//  mode : 00 sign, 01 zero, 10 sign<<2 (MSBs dropped), 11 treated as sign
//  ext  : extended result
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]   imm,
  input  logic [MODE_W-1:0] mode,
  output logic [OUT_W-1:0]  ext
);

  logic [OUT_W-1:0] sext;

  always_comb begin
    sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    ext  = sext;
    case (mode_e'(mode))
      MODE_ZERO: ext = {{(OUT_W-IN_W){1'b0}}, imm};
      MODE_BR:   ext = sext << 2;
      default:   ext = sext;
    endcase
  end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin share of one immediate-extension unit between NUM_REQ requesters.
//  Clk, Rst_n : clock (rising edge) and asynchronous active-low reset
//  bus        : request channels and single registered response slot
//  busy_cnt   : saturating count of cycles with at least one request stalled
module imm_ext_arbiter
  import imm_ext_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IN_W    = 16,
  parameter int unsigned OUT_W   = 32
) (
  input  logic               Clk,
  input  logic               Rst_n,
  imm_ext_arbiter_if.slave   bus,
  output logic [15:0]        busy_cnt
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  slot_e               state;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     gnt_id;
  logic                gnt_found;
  logic [NUM_REQ-1:0]  gnt;
  logic                can_accept;
  logic                stalled;
  logic [IN_W-1:0]     imm_sel;
  logic [MODE_W-1:0]   mode_sel;
  logic [OUT_W-1:0]    ext;

  // Scan from the rr pointer upward with wrap; first valid requester wins.
  // Rst_n gates the grant so req_ready stays low throughout reset.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    can_accept = (state == SLOT_EMPTY) || bus.rsp_ready;
    gnt_found  = 1'b0;
    gnt_id     = '0;
    if (can_accept && Rst_n) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = (32'(ptr) + k) % NUM_REQ;
        if (!gnt_found && bus.req_valid[idx]) begin
          gnt_found = 1'b1;
          gnt_id    = ID_W'(idx);
        end
      end
    end
    gnt         = '0;
    gnt[gnt_id] = gnt_found;
    stalled     = |(bus.req_valid & ~gnt);
    imm_sel     = bus.req_imm[gnt_id*IN_W +: IN_W];
    mode_sel    = bus.req_mode[gnt_id*MODE_W +: MODE_W];
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = (state == SLOT_FULL);

  imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .imm  (imm_sel),
    .mode (mode_sel),
    .ext  (ext)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= SLOT_EMPTY;
      bus.rsp_data <= '0;
      bus.rsp_id   <= '0;
      ptr          <= '0;
      busy_cnt     <= '0;
    end else begin
      if (gnt_found) begin
        state        <= SLOT_FULL;
        bus.rsp_data <= ext;
        bus.rsp_id   <= gnt_id;
        ptr          <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
      end else if (bus.rsp_ready) begin
        state <= SLOT_EMPTY;
      end
      if (stalled && (busy_cnt != '1))
        busy_cnt <= busy_cnt + 1'b1;
    end
  end

endmodule
